// File: rtl/da_pkg.sv
// Shared types and constants for the distributed-arithmetic row engines.
package da_pkg;

  localparam int ROM_W  = 16;
  localparam int ADDR_W = 3;
  localparam int Q_FRAC = 14;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } da_state_e;

  // Accumulator needs one extra bit beyond sample*coefficient width.
  function automatic int acc_width(input int in_w);
    return in_w + ROM_W + 1;
  endfunction

endpackage

// File: rtl/da_row_engine_if.sv
// Sample, ROM and result signals of one DA row engine.
interface da_row_engine_if
  import da_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int ACC_W = acc_width(IN_W)
);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   x0;
  logic [IN_W-1:0]   x1;
  logic [IN_W-1:0]   x2;
  logic [IN_W-1:0]   x3;
  logic              rom_cs;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  dout;

  modport master (
    input  in_valid, x0, x1, x2, x3, rom_data, out_ready,
    output in_ready, rom_cs, rom_addr, out_valid, dout
  );

  modport slave (
    output in_valid, x0, x1, x2, x3, rom_data, out_ready,
    input  in_ready, rom_cs, rom_addr, out_valid, dout
  );

endinterface

// File: rtl/da_slice_addr.sv
// Maps a 4-bit DA slice onto the half-size ROM address plus a negate flag.
module da_slice_addr
  import da_pkg::*;
(
  input  logic [3:0]        i_bits,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_neg
);

  // Mirror symmetry F({1,c}) = -F({0,~c}) halves the table.
  assign o_neg  = i_bits[3];
  assign o_addr = i_bits[3] ? ~i_bits[2:0] : i_bits[2:0];

endmodule

// File: rtl/da_row_engine.sv
// DA row engine: bit-serial MSB-first walk over four samples, one ROM read per slice.
// Optional macro DA_ROM_REG_EN registers rom_data before the adder and adds a DRAIN state.
module da_row_engine
  import da_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int ACC_W = acc_width(IN_W)
) (
  input logic           clk,
  input logic           rst,
  da_row_engine_if.master bus
);

  localparam int BIT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(IN_W - 1);

  da_state_e r_state;
  da_state_e w_state_nxt;

  logic [IN_W-1:0]          r_x0, r_x1, r_x2, r_x3;
  logic [BIT_W-1:0]         r_bit;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_dout;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_sum;
  logic [3:0]               w_slice;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_neg;
  logic                     w_sign;
  logic                     w_accept;
  logic                     w_last;

  assign w_slice = {r_x0[r_bit], r_x1[r_bit], r_x2[r_bit], r_x3[r_bit]};

  da_slice_addr u_slice_addr (
    .i_bits (w_slice),
    .o_addr (w_addr),
    .o_neg  (w_neg)
  );

  assign w_ext = {{(ACC_W - ROM_W){bus.rom_data[ROM_W-1]}}, bus.rom_data};

`ifdef DA_ROM_REG_EN
  logic signed [ACC_W-1:0] r_data_q;
  logic                    r_neg_q;
  logic                    r_sign_q;
  logic                    r_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_q <= '0;
      r_neg_q  <= 1'b0;
      r_sign_q <= 1'b0;
      r_vld_q  <= 1'b0;
    end else begin
      r_data_q <= w_ext;
      r_neg_q  <= w_neg;
      r_sign_q <= (r_bit == BIT_TOP);
      r_vld_q  <= (r_state == RUN);
    end
  end

  assign w_term = r_neg_q ? -r_data_q : r_data_q;
  assign w_sign = r_sign_q;
`else
  assign w_term = w_neg ? -w_ext : w_ext;
  assign w_sign = (r_bit == BIT_TOP);
`endif

  // The sign slice carries negative weight, so it seeds the accumulator negated.
  assign w_sum = w_sign ? -w_term : (r_acc <<< 1) + w_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_bit == '0) begin
          w_last = 1'b1;
`ifdef DA_ROM_REG_EN
          w_state_nxt = DRAIN;
`else
          w_state_nxt = DONE;
`endif
        end
      end
      DRAIN:   w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0   <= '0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_x3   <= '0;
      r_bit  <= BIT_TOP;
      r_acc  <= '0;
      r_dout <= '0;
    end else begin
      if (w_accept) begin
        r_x0  <= bus.x0;
        r_x1  <= bus.x1;
        r_x2  <= bus.x2;
        r_x3  <= bus.x3;
        r_bit <= BIT_TOP;
        r_acc <= '0;
      end
      if (r_state == RUN && r_bit != '0) r_bit <= r_bit - 1'b1;
`ifdef DA_ROM_REG_EN
      if (r_state == RUN && r_vld_q) r_acc <= w_sum;
      if (r_state == DRAIN) begin
        r_acc  <= w_sum;
        r_dout <= w_sum;
      end
`else
      if (r_state == RUN) begin
        r_acc <= w_sum;
        if (w_last) r_dout <= w_sum;
      end
`endif
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.rom_cs    = (r_state == RUN);
  assign bus.rom_addr  = (r_state == RUN) ? w_addr : '0;
  assign bus.out_valid = (r_state == DONE);
  assign bus.dout      = r_dout;

endmodule

// File: tb/tb_da_row_engine.sv
// Directed bench for da_row_engine wired to a Z7-style half ROM model.
module tb_da_row_engine;
  import da_pkg::*;

  localparam int IN_W  = 12;
  localparam int ACC_W = acc_width(IN_W);
`ifdef DA_ROM_REG_EN
  localparam int LAT = IN_W + 1;
`else
  localparam int LAT = IN_W;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  da_row_engine_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

  da_row_engine #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entries 0 and 7 are the Z7 values; the rest are arbitrary distinct words.
  function automatic logic [15:0] z7_rom(input logic [2:0] a);
    case (a)
      3'd0:    return 16'sd4176;
      3'd1:    return -16'sd1000;
      3'd2:    return 16'sd2000;
      3'd3:    return 16'sd1234;
      3'd4:    return -16'sd3000;
      3'd5:    return 16'sd500;
      3'd6:    return -16'sd250;
      default: return -16'sd7373;
    endcase
  endfunction

  always_comb begin
    bus.rom_data = '0;
    if (bus.rom_cs) bus.rom_data = z7_rom(bus.rom_addr);
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input logic [IN_W-1:0] c, input logic [IN_W-1:0] d,
                         input longint exp, input string tag,
                         input bit early_rdy, input int stall);
    int cnt;
    @(negedge clk);
    bus.x0 = a; bus.x1 = b; bus.x2 = c; bus.x3 = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = early_rdy;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val({tag, "_run_cs"}, longint'(bus.rom_cs), 1);
    check_val({tag, "_run_rdy"}, longint'(bus.in_ready), 0);
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check_val({tag, "_lat"}, cnt, LAT);
    check_val({tag, "_dout"}, longint'($signed(bus.dout)), exp);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.x0 = 12'h555; bus.x1 = 12'h2AA; bus.x2 = 12'h123; bus.x3 = 12'h7FF;
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_hold_vld"}, longint'(bus.out_valid), 1);
      check_val({tag, "_hold_dout"}, longint'($signed(bus.dout)), exp);
      check_val({tag, "_hold_rdy"}, longint'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val({tag, "_ret_vld"}, longint'(bus.out_valid), 0);
    check_val({tag, "_ret_rdy"}, longint'(bus.in_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"}, longint'(bus.in_ready), 1);
    check_val({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check_val({tag, "_rom_cs"}, longint'(bus.rom_cs), 0);
    check_val({tag, "_rom_addr"}, longint'(bus.rom_addr), 0);
    check_val({tag, "_dout"}, longint'($signed(bus.dout)), 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
    #2;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Expected dout = -2048*T11 + sum 2^b*T_b over the slice terms.
    run_txn(12'h000, 12'h000, 12'h000, 12'h000, -4176,    "zeros",  1'b0, 0);
    run_txn(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4176,     "ones",   1'b0, 0);
    run_txn(12'h001, 12'h000, 12'h000, 12'h000, -979,     "x0_one", 1'b0, 5);
    run_txn(12'h000, 12'h000, 12'h001, 12'h001, -7118,    "addr3",  1'b1, 0);
    run_txn(12'h001, 12'h001, 12'h001, 12'h001, -12528,   "all1",   1'b0, 0);
    run_txn(12'h800, 12'h000, 12'h000, 12'h000, -6551632, "x0_min", 1'b0, 0);

    // Reset in the middle of RUN must discard the partial result.
    @(negedge clk);
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_txn(12'h000, 12'h000, 12'h000, 12'h000, -4176, "post_rst", 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/da_row_engine.md
Name: da_row_engine

Overview:
- Initiator and reader for the distributed-arithmetic (DA) coefficient ROMs in the DCT datapath.
- Accepts four signed EEG samples x0..x3. Walks their bits MSB-first, one bit-slice per cycle.
- For each slice it forms a half-table ROM address, reads a 16-bit Q2.14 coefficient sum, and shift-accumulates it into one DCT output coefficient (e.g. Z7 when wired to the Z7 ROM).
- One instance per ROM, sitting between the sample buffer and the output quantiser.

Parameters:
- IN_W, 12: sample width, two's complement. Also the number of RUN cycles.
- ROM_W, 16: ROM word width, Q2.14 two's complement.
- ACC_W, IN_W+ROM_W+1 (29): accumulator and result width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: x0..x3 valid.
- in_ready, output, 1: engine can accept samples.
- x0, x1, x2, x3, input, IN_W each: signed samples.
- rom_cs, output, 1: ROM chip select.
- rom_addr, output, 3: ROM address.
- rom_data, input, ROM_W: ROM word, combinational from rom_addr/rom_cs.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- dout, output, ACC_W: signed result.

Behaviour:
- Reset values: state=IDLE, acc=0, bit index=IN_W-1, in_ready=1, out_valid=0, dout=0, rom_cs=0, rom_addr=0.
- in_ready = (state==IDLE). rom_cs = (state==RUN). rom_addr = 0 whenever rom_cs=0.
- IDLE: on in_valid && in_ready, register x0..x3, set acc=0 and bit index b=IN_W-1, go to RUN.
- RUN (IN_W cycles, b = IN_W-1 down to 0):
  - Form slice a = {x0[b], x1[b], x2[b], x3[b]}.
  - If a[3]=0: rom_addr = a[2:0], term = +sext(rom_data).
  - If a[3]=1: rom_addr = ~a[2:0], term = -sext(rom_data). This is the half-ROM mirror F({1,c}) = -F({0,~c}).
  - Accumulate: acc <= (acc <<< 1) + term. On the sign bit (b=IN_W-1) subtract instead: acc <= -term.
  - After b=0, go to DONE and latch dout=acc.
- DONE: out_valid=1. dout and out_valid are held stable until out_ready=1. On that edge out_valid falls and the state returns to IDLE.
- Latency: samples accepted at edge T; out_valid is high from cycle T+IN_W+1.
- Throughput: one result per IN_W+2 cycles minimum. No back-to-back accept, because in_ready=0 in DONE.
- out_ready while out_valid=0: ignored. in_valid outside IDLE: ignored, and the samples are not captured.
- Arithmetic:
  - rom_data is sign-extended to ACC_W. The accumulator is wide enough that no overflow is possible.
  - No rounding: dout keeps Q2.14 fraction bits, so the result is scaled by 2^14.
- rom_data is consumed as delivered, including 0 while the ROM is held in its own reset.
- Reset mid-RUN or mid-DONE: asynchronously return to IDLE with all outputs at reset values. The partial result is discarded.

Optional Feature:
- Macro: DA_ROM_REG_EN.
- Defined:
  - rom_data is registered before the adder, and the slice sign a[3] is delayed to match.
  - RUN is followed by one DRAIN state (rom_cs=0) that adds the final term.
  - Latency becomes T+IN_W+2. Results are identical.
- Undefined: rom_data is used combinationally in the same cycle, as described above.

Decomposition:
- Package da_pkg:
  - ROM_W=16 and ADDR_W=3.
  - Q_FRAC=14.
  - Enumerated state type IDLE/RUN/DRAIN/DONE.
  - Function acc_width(in_w).
- Sub-module da_slice_addr (combinational): takes the four sample bits, outputs rom_addr[2:0] and negate flag. It is reusable by all eight row engines.

Test Plan:
- Wired to the Z7 ROM, x0..x3 = 0 → every slice addr 0, term +4176 → dout = 4176*(2047-2048) = -4176, out_valid at T+13.
- x0..x3 = 0xFFF (-1 each) → addr 0 negated every slice → dout = +4176.
- x0=1, others 0:
  - bit 0 → addr 7, term -(-7373) = +7373.
  - other bits → addr 0.
  - dout = -8352 + 7373 = -979.
- Hold out_ready=0 for 5 cycles in DONE → dout and out_valid stable, in_ready=0, a new in_valid is ignored. Raise out_ready → IDLE next cycle.
- Assert rst at RUN cycle 6 → all outputs at reset values immediately. After release, the next transaction with all-zero samples yields -4176.
- Build with DA_ROM_REG_EN and repeat the three value cases above → same dout, out_valid at T+14.
